// File: rtl/register_write_demux.sv
// Write side of the register bank: decodes wr_addr and loads wr_data into one register.
// Latency: written data, sel_onehot and wr_ack all appear one clk edge after wr_en is sampled.
// Backpressure: none; a write is accepted every cycle, and clear takes priority over any write.
module register_write_demux #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    localparam int NUM_REGS = 2 ** ADDR_BITS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [ADDR_BITS-1:0]      wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [NUM_REGS*WIDTH-1:0] regs_flat,
    output logic [NUM_REGS-1:0]       sel_onehot,
    output logic                      wr_ack,
    output logic                      wr_dropped
);

    logic [NUM_REGS-1:0] dec;
    logic                wr_drop;
    logic                wr_commit;
    logic [WIDTH-1:0]    regs [NUM_REGS];

    assign dec       = wr_en ? (NUM_REGS'(1) << wr_addr) : '0;
    assign wr_drop   = wr_en && (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_commit = wr_en && !wr_drop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0 && ZERO_REG != 0) begin : g_zero
                // Hardwired zero register: no storage at all.
                assign regs[gi] = '0;
            end else begin : g_store
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        regs[gi] <= '0;
                    end else if (clear) begin
                        regs[gi] <= '0;
                    end else if (wr_commit && dec[gi]) begin
                        regs[gi] <= wr_data;
                    end
                end
            end
            assign regs_flat[gi*WIDTH +: WIDTH] = regs[gi];
        end
    endgenerate

    // Status flags reflect only the edge just taken; they never stretch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_onehot <= '0;
            wr_ack     <= 1'b0;
            wr_dropped <= 1'b0;
        end else if (clear) begin
            sel_onehot <= '0;
            wr_ack     <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            sel_onehot <= wr_commit ? dec : '0;
            wr_ack     <= wr_commit;
            wr_dropped <= wr_drop;
        end
    end

endmodule
